// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported req/ack memory bus between the
// instruction-fetch port and the load/store port.  Data wins a conflict
// unless it also won the previous grant, so fetch cannot be starved.
// Every access goes IDLE -> *_ACC -> *_DONE -> IDLE.  The DONE state
// carries the one-cycle ready pulse and gives one turnaround cycle.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              flush_i,
    // load/store port
    input  logic              dm_ce_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic [DATA_W-1:0] dm_data_o,
    output logic              dm_ready_o,
    // pipeline control
    output logic              stallreq_o,
    // memory bus
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_ACC  = 3'd1,
        DM_ACC  = 3'd2,
        IF_DONE = 3'd3,
        DM_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_dm;
    logic                r_drop;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [3:0]          r_bus_sel;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_dm_data;

    logic                w_if_want;
    logic                w_dm_grant;
    logic                w_if_grant;

    // A flushed fetch is not a candidate for a grant at all.
    assign w_if_want  = if_ce_i & ~flush_i;
    assign w_dm_grant = (r_state == IDLE) & dm_ce_i & (~w_if_want | ~r_last_dm);
    assign w_if_grant = (r_state == IDLE) & w_if_want & (~dm_ce_i | r_last_dm);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_dm_grant)      w_next = DM_ACC;
                else if (w_if_grant) w_next = IF_ACC;
            end
            IF_ACC:  if (bus_ack_i) w_next = IF_DONE;
            DM_ACC:  if (bus_ack_i) w_next = DM_DONE;
            IF_DONE: w_next = IDLE;
            DM_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus request registers, fairness bit, fetch-drop flag and read capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_dm   <= 1'b0;
            r_drop      <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'b0000;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_data   <= '0;
            r_dm_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_dm_grant) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= dm_we_i;
                        r_bus_sel   <= dm_sel_i;
                        r_bus_addr  <= dm_addr_i;
                        r_bus_wdata <= dm_data_i;
                        r_last_dm   <= 1'b1;
                    end else if (w_if_grant) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= 4'b1111;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= '0;
                        r_last_dm   <= 1'b0;
                    end
                end
                IF_ACC: begin
                    // The bus cycle always completes; a flush only
                    // suppresses delivery of its result.
                    if (flush_i) r_drop <= 1'b1;
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        if (!r_drop && !flush_i) r_if_data <= bus_rdata_i;
                    end
                end
                DM_ACC: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) r_dm_data <= bus_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign if_data_o   = r_if_data;
    assign dm_data_o   = r_dm_data;

    assign if_ready_o  = (r_state == IF_DONE) & ~r_drop;
    assign dm_ready_o  = (r_state == DM_DONE);

    // Stall while a request is outstanding; forced low during reset so
    // every output is quiet while rst is asserted.
    assign stallreq_o  = rst & ((dm_ce_i & ~dm_ready_o) |
                                (if_ce_i & ~if_ready_o & ~flush_i));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.  Inputs are driven 2 time units
// after each rising edge; outputs are checked in the same slot or 1 unit
// after a new input is applied, never on the edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_ce_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_data_o;
    logic          if_ready_o;
    logic          flush_i;
    logic          dm_ce_i;
    logic          dm_we_i;
    logic [3:0]    dm_sel_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_data_i;
    logic [DW-1:0] dm_data_o;
    logic          dm_ready_o;
    logic          stallreq_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [3:0]    bus_sel_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic [DW-1:0] bus_rdata_i;
    logic          bus_ack_i;

    int n_vec;
    int n_err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_ready_o(if_ready_o), .flush_i(flush_i),
        .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
        .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i), .dm_data_o(dm_data_o),
        .dm_ready_o(dm_ready_o), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_ce_i = 1'b1; dm_ce_i = 1'b1; flush_i = 1'b0;
        if_addr_i = 32'h100; dm_we_i = 1'b0; dm_sel_i = 4'b0;
        dm_addr_i = '0; dm_data_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
        #3;
        if ({bus_req_o, if_ready_o, dm_ready_o, stallreq_o} !== 4'b0000) begin
            $display("FAIL reset_ctl: req/ifr/dmr/stall=%b want 0000",
                     {bus_req_o, if_ready_o, dm_ready_o, stallreq_o});
            n_err++;
        end
        n_vec++;
        if ({if_data_o, dm_data_o, bus_addr_o} !== 96'h0) begin
            $display("FAIL reset_data: if=%h dm=%h addr=%h want 0", if_data_o, dm_data_o, bus_addr_o);
            n_err++;
        end
        n_vec++;
        dm_ce_i = 1'b0;
    endtask

    task automatic test_fetch();
        @(posedge clk); #2;
        rst = 1'b1;                      // cycle 0: fetch pending in IDLE
        #1;
        if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
            $display("FAIL fetch_c0: stall=%b req=%b want 1 0", stallreq_o, bus_req_o);
            n_err++;
        end
        n_vec++;
        tick();                          // cycle 1
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF) begin
            $display("FAIL fetch_req: req=%b addr=%h we=%b sel=%h want 1 100 0 f",
                     bus_req_o, bus_addr_o, bus_we_o, bus_sel_o);
            n_err++;
        end
        n_vec++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h24010005;
        tick();                          // cycle 2
        bus_ack_i = 1'b0;
        if (if_ready_o !== 1'b1 || if_data_o !== 32'h24010005 || stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin
            $display("FAIL fetch_done: rdy=%b data=%h stall=%b req=%b want 1 24010005 0 0",
                     if_ready_o, if_data_o, stallreq_o, bus_req_o);
            n_err++;
        end
        n_vec++;
        if_ce_i = 1'b0;
        tick();                          // back in IDLE
        if (if_ready_o !== 1'b0) begin
            $display("FAIL fetch_pulse: rdy=%b want 0", if_ready_o);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_load();
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2000; dm_sel_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (c == 4) begin bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF; end
            #1;
            if (stallreq_o !== 1'b1 || dm_ready_o !== 1'b0 || (c > 0 && bus_req_o !== 1'b1)) begin
                $display("FAIL load_wait c%0d: stall=%b rdy=%b req=%b want 1 0 1",
                         c, stallreq_o, dm_ready_o, bus_req_o);
                n_err++;
            end
            n_vec++;
        end
        tick();                          // cycle 5
        bus_ack_i = 1'b0;
        if (dm_ready_o !== 1'b1 || dm_data_o !== 32'hDEADBEEF || stallreq_o !== 1'b0) begin
            $display("FAIL load_done: rdy=%b data=%h stall=%b want 1 deadbeef 0",
                     dm_ready_o, dm_data_o, stallreq_o);
            n_err++;
        end
        n_vec++;
        dm_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011;
        dm_addr_i = 32'h2004; dm_data_i = 32'h0000ABCD;
        bus_rdata_i = 32'h11111111;      // must not reach dm_data_o
        for (int c = 1; c <= 2; c++) begin
            tick();
            if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_sel_o !== 4'b0011 ||
                bus_wdata_o !== 32'h0000ABCD || bus_addr_o !== 32'h2004) begin
                $display("FAIL store_bus c%0d: req=%b we=%b sel=%b wd=%h a=%h want 1 1 0011 0000abcd 2004",
                         c, bus_req_o, bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o);
                n_err++;
            end
            n_vec++;
        end
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        if (dm_ready_o !== 1'b1 || dm_data_o !== 32'hDEADBEEF) begin
            $display("FAIL store_done: rdy=%b data=%h want 1 deadbeef", dm_ready_o, dm_data_o);
            n_err++;
        end
        n_vec++;
        dm_ce_i = 1'b0; dm_we_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        if_ce_i = 1'b1; if_addr_i = 32'h180;
        tick();                          // IF_ACC
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h180) begin
            $display("FAIL flush_req: req=%b addr=%h want 1 180", bus_req_o, bus_addr_o);
            n_err++;
        end
        n_vec++;
        flush_i = 1'b1; if_addr_i = 32'h200;
        tick();
        flush_i = 1'b0;
        if (bus_addr_o !== 32'h180 || bus_req_o !== 1'b1) begin
            $display("FAIL flush_hold: addr=%h req=%b want 180 1", bus_addr_o, bus_req_o);
            n_err++;
        end
        n_vec++;
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0BAD0;
        tick();                          // IF_DONE, dropped
        bus_ack_i = 1'b0;
        if (if_ready_o !== 1'b0 || if_data_o !== 32'h24010005) begin
            $display("FAIL flush_drop: rdy=%b data=%h want 0 24010005", if_ready_o, if_data_o);
            n_err++;
        end
        n_vec++;
        tick();                          // IDLE, grants 0x200
        tick();
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h200) begin
            $display("FAIL refetch_req: req=%b addr=%h want 1 200", bus_req_o, bus_addr_o);
            n_err++;
        end
        n_vec++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3C1D1000;
        tick();
        bus_ack_i = 1'b0;
        if (if_ready_o !== 1'b1 || if_data_o !== 32'h3C1D1000) begin
            $display("FAIL refetch_done: rdy=%b data=%h want 1 3c1d1000", if_ready_o, if_data_o);
            n_err++;
        end
        n_vec++;
        if_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic exp_dm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic got_dm [4];
        int   ng = 0;
        if_ce_i = 1'b1; if_addr_i = 32'h300;
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3000; dm_sel_i = 4'hF;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (bus_req_o && !bus_ack_i) begin
                got_dm[ng] = (bus_addr_o == 32'h3000);
                ng++;
                bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE0000 + 32'(c);
            end else begin
                bus_ack_i = 1'b0;
            end
        end
        if (ng != 4) begin
            $display("FAIL fair_timeout: grants=%0d want 4", ng);
            n_err++;
        end
        n_vec++;
        for (int i = 0; i < ng; i++) begin
            if (got_dm[i] !== exp_dm[i]) begin
                $display("FAIL fair_order g%0d: data_grant=%b want %b", i, got_dm[i], exp_dm[i]);
                n_err++;
            end
            n_vec++;
        end
        tick();                          // DONE of last grant
        bus_ack_i = 1'b0; if_ce_i = 1'b0; dm_ce_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2008; dm_sel_i = 4'hF;
        tick();                          // DM_ACC
        if (bus_req_o !== 1'b1) begin
            $display("FAIL areset_pre: req=%b want 1", bus_req_o);
            n_err++;
        end
        n_vec++;
        #1 rst = 1'b0;
        #1;
        if ({bus_req_o, dm_ready_o, if_ready_o, stallreq_o} !== 4'b0000 || dm_data_o !== '0) begin
            $display("FAIL areset_mid: req/dmr/ifr/stall=%b dm=%h want 0000 0",
                     {bus_req_o, dm_ready_o, if_ready_o, stallreq_o}, dm_data_o);
            n_err++;
        end
        n_vec++;
        dm_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h55AA55AA;
        #1 rst = 1'b1;
        tick();                          // late ack lands in IDLE
        bus_ack_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (dm_ready_o !== 1'b0 || bus_req_o !== 1'b0 || dm_data_o !== '0) begin
                $display("FAIL areset_ack c%0d: rdy=%b req=%b dm=%h want 0 0 0",
                         c, dm_ready_o, bus_req_o, dm_data_o);
                n_err++;
            end
            n_vec++;
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_flush();
        test_fairness();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported memory bus between instruction fetch (pc_reg/if_id side) and the mem stage's load/store port.
- Sits between the CPU core and a unified SRAM/bus with a req/ack handshake.
- Grants one requester at a time, registers the bus request, and returns captured read data with a one-cycle ready pulse.
- Drives a stall request to ctrl while either requester is waiting.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width of both requesters and the bus

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
if_ce_i  in  1  fetch request; held until if_ready_o
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched instruction, valid when if_ready_o
if_ready_o  out  1  fetch complete, one-cycle pulse
flush_i  in  1  discard the in-flight fetch result
dm_ce_i  in  1  data request; held until dm_ready_o
dm_we_i  in  1  1 = store, 0 = load
dm_sel_i  in  4  byte lane enables
dm_addr_i  in  ADDR_W  data address
dm_data_i  in  DATA_W  store data
dm_data_o  out  DATA_W  load data, valid when dm_ready_o
dm_ready_o  out  1  data access complete, one-cycle pulse
stallreq_o  out  1  pipeline stall request to ctrl
bus_req_o  out  1  bus request, held until bus_ack_i
bus_we_o  out  1  bus write enable
bus_sel_o  out  4  bus byte enables
bus_addr_o  out  ADDR_W  bus address
bus_wdata_o  out  DATA_W  bus write data
bus_rdata_i  in  DATA_W  bus read data, valid with bus_ack_i
bus_ack_i  in  1  bus completion, one cycle

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE and last_dm = 0. All outputs clear to 0 immediately, including bus_req_o and both ready outputs. This holds mid-transaction; the bus is required to tolerate a dropped request.
- States: IDLE, IF_ACC, DM_ACC, IF_DONE, DM_DONE.
- IDLE, grant rule:
  - Only dm_ce_i set: grant data.
  - Only if_ce_i set: grant fetch.
  - Both set: grant data, unless last_dm = 1; then grant fetch. This prevents fetch starvation.
- On grant, at the clock edge:
  - Register address, we, sel and wdata onto the bus_* outputs; set bus_req_o = 1.
  - Enter IF_ACC or DM_ACC; set last_dm to 1 for a data grant, 0 for a fetch grant.
  - A fetch grant forces bus_we_o = 0 and bus_sel_o = 4'b1111.
- IF_ACC / DM_ACC:
  - Hold all bus_* outputs stable until bus_ack_i.
  - On the ack edge: bus_req_o goes to 0, bus_rdata_i is captured into the requester's data register, next state is the matching DONE state.
- IF_DONE / DM_DONE: the matching ready output is 1 for exactly this cycle; next state is IDLE unconditionally. There is one turnaround cycle between grants.
- Latency: ce seen in IDLE at cycle 0 gives bus_req_o in cycle 1. With ack in cycle 1, ready is in cycle 2. Each bus wait state adds one cycle.
- Data outputs:
  - if_data_o and dm_data_o hold their last captured value until the next capture.
  - A store captures nothing; dm_data_o is unchanged.
- stallreq_o (combinational) = (dm_ce_i & ~dm_ready_o) | (if_ce_i & ~if_ready_o & ~flush_i).
- Flush:
  - flush_i during IF_ACC: the bus transaction still completes. A sticky drop flag is set; in IF_DONE, if_ready_o stays 0 and if_data_o is not updated.
  - flush_i in IDLE with only if_ce_i pending: no fetch grant that cycle.
  - Data accesses are never flushed.
- bus_ack_i outside IF_ACC/DM_ACC is ignored.
- Requesters are required to deassert ce, or present a new request, the cycle after ready. The arbiter is back in IDLE by then, so no stale re-grant occurs.

Test Plan:
1. Reset release, if_ce_i=1, addr 0x100, bus acks the first req cycle with rdata 0x24010005 -> bus_req_o=1 in cycle 1, if_ready_o=1 and if_data_o=0x24010005 in cycle 2, stallreq_o=0 in cycle 2.
2. Load: dm_ce_i=1, we=0, addr 0x2000, sel 4'b1111; bus inserts 3 wait states, then rdata 0xDEADBEEF -> dm_ready_o pulses at cycle 5; stallreq_o=1 in cycles 0-4.
3. Fairness: if_ce_i and dm_ce_i held from cycle 0, every access acked immediately -> grant order data, fetch, data, fetch. No requester receives two consecutive grants while the other is pending.
4. Store: we=1, sel 4'b0011, data 0x0000ABCD, addr 0x2004 -> bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=0x0000ABCD held until ack; dm_data_o keeps its prior value 0xDEADBEEF.
5. Flush: fetch in IF_ACC, flush_i pulses for 1 cycle, ack 2 cycles later -> if_ready_o stays 0 and if_data_o is unchanged. The next fetch to 0x200 completes normally.
6. Async reset: assert rst low mid-DM_ACC, between clock edges -> bus_req_o and stallreq-related state clear immediately. After release the state is IDLE, and a late bus_ack_i is ignored.
